// File: rtl/add_full.sv
// Registered WIDTH-bit ripple-carry full adder with a valid strobe.
// Define ADD_FULL_OVF_EN to add the registered signed-overflow output ovf.
module add_full #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] soma,
  output logic             cout
`ifdef ADD_FULL_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

`ifdef ADD_FULL_OVF_EN
  logic ovf_d;
  // For WIDTH=1, c[WIDTH-1] is cin itself.
  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];
`endif

  // Outputs hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      soma      <= '0;
      cout      <= 1'b0;
`ifdef ADD_FULL_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        soma <= s;
        cout <= c[WIDTH];
`ifdef ADD_FULL_OVF_EN
        ovf  <= ovf_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_add_full.sv
// Randomized self-checking bench for add_full at WIDTH=1 and WIDTH=8.
// Reference model uses plain integer arithmetic on the operands.
module tb_add_full;

  logic clk = 1'b0;
  logic rst;

  logic       iv1, a1, b1, ci1;
  logic       ov1, s1, co1;
  logic       iv8, ci8;
  logic [7:0] a8, b8;
  logic       ov8, co8;
  logic [7:0] s8;
`ifdef ADD_FULL_OVF_EN
  logic       of1, of8;
`endif

  int errs = 0;
  int checks = 0;

  // model state: valid, sum, carry, overflow
  logic       m1v, m1s, m1c, m1o;
  logic       m8v, m8c, m8o;
  logic [7:0] m8s;

  always #5 clk = ~clk;

  add_full #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1),
    .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .soma(s1), .cout(co1)
`ifdef ADD_FULL_OVF_EN
    , .ovf(of1)
`endif
  );

  add_full #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8),
    .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .soma(s8), .cout(co8)
`ifdef ADD_FULL_OVF_EN
    , .ovf(of8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unsigned sum plus two's-complement range check for overflow.
  function automatic void model(input int w, input int a, input int b,
                                input int ci, output int s, output int c,
                                output int o);
    int sum, sa, sb, ss, half;
    half = 1 << (w - 1);
    sum  = a + b + ci;
    s    = sum % (1 << w);
    c    = sum >> w;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    ss   = sa + sb + ci;
    o    = (ss < -half || ss >= half) ? 1 : 0;
  endfunction

  task automatic step();
    int s, c, o;
    @(posedge clk);
    if (rst) begin
      {m1v, m1s, m1c, m1o} = '0;
      {m8v, m8s, m8c, m8o} = '0;
    end else begin
      m1v = iv1;
      if (iv1) begin
        model(1, int'(a1), int'(b1), int'(ci1), s, c, o);
        m1s = s[0]; m1c = c[0]; m1o = o[0];
      end
      m8v = iv8;
      if (iv8) begin
        model(8, int'(a8), int'(b8), int'(ci8), s, c, o);
        m8s = s[7:0]; m8c = c[0]; m8o = o[0];
      end
    end
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " v1"}, 32'(ov1), 32'(m1v));
    chk({tag, " s1"}, 32'(s1), 32'(m1s));
    chk({tag, " c1"}, 32'(co1), 32'(m1c));
    chk({tag, " v8"}, 32'(ov8), 32'(m8v));
    chk({tag, " s8"}, 32'(s8), 32'(m8s));
    chk({tag, " c8"}, 32'(co8), 32'(m8c));
`ifdef ADD_FULL_OVF_EN
    chk({tag, " o1"}, 32'(of1), 32'(m1o));
    chk({tag, " o8"}, 32'(of8), 32'(m8o));
`endif
  endtask

  initial begin
    rst = 1'b1;
    {iv1, a1, b1, ci1} = '0;
    {iv8, ci8} = '0;
    a8 = '0; b8 = '0;
    step();
    step();
    chk("rst v1", 32'(ov1), 32'd0);
    chk("rst s1", 32'(s1), 32'd0);
    chk("rst c1", 32'(co1), 32'd0);
    chk("rst v8", 32'(ov8), 32'd0);
    chk("rst s8", 32'(s8), 32'd0);
    chk("rst c8", 32'(co8), 32'd0);
    rst = 1'b0;

    // single carry-in only
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b1;
    step();
    chk("cin only v", 32'(ov1), 32'd1);
    chk("cin only s", 32'(s1), 32'd1);
    chk("cin only c", 32'(co1), 32'd0);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      {a1, b1, ci1} = v;
      step();
      chk("exh sum", 32'({co1, s1}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
    end

    iv1 = 1'b0;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    step();
    chk("ff+01 s", 32'(s8), 32'h00);
    chk("ff+01 c", 32'(co8), 32'd1);
`ifdef ADD_FULL_OVF_EN
    chk("ff+01 o", 32'(of8), 32'd0);
`endif
    a8 = 8'h7F;
    step();
    chk("7f+01 s", 32'(s8), 32'h80);
    chk("7f+01 c", 32'(co8), 32'd0);
`ifdef ADD_FULL_OVF_EN
    chk("7f+01 o", 32'(of8), 32'd1);
`endif
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    step();
    chk("wrap s", 32'(s8), 32'hFF);
    chk("wrap c", 32'(co8), 32'd1);

    // idle with unknown operands must hold results
    iv1 = 1'b0; iv8 = 1'b0;
    a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
    a8 = 'x; b8 = 'x; ci8 = 1'bx;
    step();
    chk_all("idle");
    chk("idle hold s8", 32'(s8), 32'hFF);

    for (int k = 0; k < 300; k++) begin
      iv1 = 1'($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      iv8 = 1'($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      step();
      chk_all("rand");
    end

    // reset lands together with the third op of a stream
    iv1 = 1'b1; iv8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = 8'h55; b8 = 8'h66; ci8 = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst v1", 32'(ov1), 32'd0);
    chk("midrst s1", 32'(s1), 32'd0);
    chk("midrst c1", 32'(co1), 32'd0);
    chk("midrst v8", 32'(ov8), 32'd0);
    chk("midrst s8", 32'(s8), 32'd0);
    chk("midrst c8", 32'(co8), 32'd0);
    iv1 = 1'b0; iv8 = 1'b0;
    step();
    chk_all("post rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
